// File: rtl/m_ext_seq_32.sv
// ============================================================================
// m_ext_seq_32 : RV32M sequencing controller for the combined mul/div datapath.
// Optional result fusing is enabled by defining M_SEQ_FUSE_EN.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module m_ext_seq_32 #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      dp_a,
    output logic [31:0]      dp_b,
    output logic             dp_sign,
    output logic             dp_mix,
    output logic             dp_mult_or_div,
    input  logic [31:0]      dp_uh,
    input  logic [31:0]      dp_lh,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag
);

    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      dp_a_q, dp_a_d, dp_b_q, dp_b_d;
    logic             sign_q, sign_d, mix_q, mix_d, md_q, md_d, sel_uh_q, sel_uh_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic             resp_valid_q, resp_valid_d;

    logic        w_sign, w_mix, w_md, w_sel_uh;
    logic        w_div0, w_ovf, w_special, w_accept, w_capture;
    logic [31:0] w_special_res, w_cap_res;
    logic        w_fuse_hit;
    logic [31:0] w_fuse_res;

    assign w_md     = req_funct3[2];
    assign w_sign   = (req_funct3 == 3'b001) | (req_funct3 == 3'b010) |
                      (req_funct3 == 3'b100) | (req_funct3 == 3'b110);
    assign w_mix    = (req_funct3 == 3'b010);
    assign w_sel_uh = w_md ? ~req_funct3[1] : (req_funct3[1:0] != 2'b00);

    // RISC-V mandated results for x/0 and INT_MIN/-1, bypassing the datapath
    assign w_div0        = w_md & (req_rs2 == 32'd0);
    assign w_ovf         = w_md & w_sign & (req_rs1 == 32'h8000_0000) & (req_rs2 == 32'hFFFF_FFFF);
    assign w_special     = w_div0 | w_ovf;
    assign w_special_res = w_div0 ? (w_sel_uh ? 32'hFFFF_FFFF : req_rs1)
                                  : (w_sel_uh ? 32'h8000_0000 : 32'd0);

    assign req_ready = (state_q == S_IDLE) & ~flush;
    assign w_accept  = req_valid & req_ready;
    assign w_capture = (state_q == S_EXEC) && (cnt_q == '0);
    assign w_cap_res = sel_uh_q ? dp_uh : dp_lh;

`ifdef M_SEQ_FUSE_EN
    logic [31:0] fuse_uh_q, fuse_lh_q;
    logic        fuse_valid_q;

    // The operand registers hold until the next accept, so they double as the key
    assign w_fuse_hit = fuse_valid_q & (req_rs1 == dp_a_q) & (req_rs2 == dp_b_q) &
                        (w_sign == sign_q) & (w_mix == mix_q) & (w_md == md_q);
    assign w_fuse_res = w_sel_uh ? fuse_uh_q : fuse_lh_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fuse_uh_q    <= 32'd0;
            fuse_lh_q    <= 32'd0;
            fuse_valid_q <= 1'b0;
        end else if (flush) begin
            fuse_valid_q <= 1'b0;
        end else if (w_capture) begin
            fuse_uh_q    <= dp_uh;
            fuse_lh_q    <= dp_lh;
            fuse_valid_q <= 1'b1;
        end else if (w_accept && w_special) begin
            fuse_valid_q <= 1'b0;
        end
    end
`else
    assign w_fuse_hit = 1'b0;
    assign w_fuse_res = 32'd0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dp_a_d       = dp_a_q;
        dp_b_d       = dp_b_q;
        sign_d       = sign_q;
        mix_d        = mix_q;
        md_d         = md_q;
        sel_uh_d     = sel_uh_q;
        tag_d        = tag_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    dp_a_d   = req_rs1;
                    dp_b_d   = req_rs2;
                    sign_d   = w_sign;
                    mix_d    = w_mix;
                    md_d     = w_md;
                    sel_uh_d = w_sel_uh;
                    tag_d    = req_tag;
                    if (w_special) begin
                        resp_data_d  = w_special_res;
                        resp_valid_d = 1'b1;
                        state_d      = S_DONE;
                    end else if (w_fuse_hit) begin
                        resp_data_d  = w_fuse_res;
                        resp_valid_d = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        cnt_d   = w_md ? DIV_LOAD : MUL_LOAD;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (w_capture) begin
                    resp_data_d  = w_cap_res;
                    resp_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dp_a_q       <= 32'd0;
            dp_b_q       <= 32'd0;
            sign_q       <= 1'b0;
            mix_q        <= 1'b0;
            md_q         <= 1'b0;
            sel_uh_q     <= 1'b0;
            tag_q        <= '0;
            resp_data_q  <= 32'd0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dp_a_q       <= dp_a_d;
            dp_b_q       <= dp_b_d;
            sign_q       <= sign_d;
            mix_q        <= mix_d;
            md_q         <= md_d;
            sel_uh_q     <= sel_uh_d;
            tag_q        <= tag_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign dp_a           = dp_a_q;
    assign dp_b           = dp_b_q;
    assign dp_sign        = sign_q;
    assign dp_mix         = mix_q;
    assign dp_mult_or_div = md_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_tag       = tag_q;

endmodule

`default_nettype wire

// File: tb/tb_m_ext_seq_32.sv
// tb_m_ext_seq_32 : scoreboard bench for m_ext_seq_32 with a behavioural mul/div datapath.
`timescale 1ns/1ps
`default_nettype none

module tb_m_ext_seq_32;

`ifdef M_SEQ_FUSE_EN
    localparam int FUSE_LAT = 0;
`else
    localparam int FUSE_LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_rs1 = 32'd0;
    logic [31:0] req_rs2 = 32'd0;
    logic [4:0]  req_tag = 5'd0;
    logic [31:0] dp_a, dp_b;
    logic        dp_sign, dp_mix, dp_mult_or_div;
    logic [31:0] dp_uh, dp_lh;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;

    m_ext_seq_32 #(.MUL_CYCLES(2), .DIV_CYCLES(4), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sign(dp_sign), .dp_mix(dp_mix),
        .dp_mult_or_div(dp_mult_or_div), .dp_uh(dp_uh), .dp_lh(dp_lh),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath; the special cases return junk so a controller that
    // forwards the datapath instead of overriding is caught.
    logic signed [63:0] m_ea, m_eb, m_p;
    always_comb begin
        m_ea  = dp_sign ? {{32{dp_a[31]}}, dp_a} : {32'd0, dp_a};
        m_eb  = (dp_sign & ~dp_mix) ? {{32{dp_b[31]}}, dp_b} : {32'd0, dp_b};
        m_p   = m_ea * m_eb;
        dp_uh = m_p[63:32];
        dp_lh = m_p[31:0];
        if (dp_mult_or_div) begin
            if (dp_b == 32'd0) begin
                dp_uh = 32'hDEAD_BEEF;
                dp_lh = 32'hDEAD_BEEF;
            end else if (dp_sign && dp_a == 32'h8000_0000 && dp_b == 32'hFFFF_FFFF) begin
                dp_uh = 32'h1234_5678;
                dp_lh = 32'h1234_5678;
            end else if (dp_sign) begin
                dp_uh = $signed(dp_a) / $signed(dp_b);
                dp_lh = $signed(dp_a) % $signed(dp_b);
            end else begin
                dp_uh = dp_a / dp_b;
                dp_lh = dp_a % dp_b;
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic [31:0] at;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare on the first cycle each response becomes visible
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (resp_valid && !prev_v) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got data %h tag %h expected no response", resp_data, resp_tag);
            end else begin
                check("resp_data", 64'(resp_data), 64'(sb[0].data));
                check("resp_tag", 64'(resp_tag), 64'(sb[0].tag));
                check("resp_latency", 64'(cyc), 64'(sb[0].at));
                sb.delete(0);
            end
        end
        prev_v <= resp_valid;
    end

    task automatic accept_only(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag, output int acc);
        int n = 0;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_tag    = tag;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
        end
        acc = cyc + 1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // lat: cycles from the accept edge until the response is visible (0 = next cycle)
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp, input int lat,
                         input logic [2:0] ctl);
        int acc;
        accept_only(f3, a, b, tag, acc);
        sb.push_back('{data: exp, tag: tag, at: 32'(acc + lat)});
        for (int i = 0; i < ((lat == 0) ? 1 : lat); i++) begin
            @(negedge clk);
            check("dp_operands", {dp_a, dp_b}, {a, b});
            if (i == 0)
                check("dp_ctrl", {61'd0, dp_sign, dp_mix, dp_mult_or_div}, {61'd0, ctl});
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(req_ready && !resp_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_timeout: got req_ready=%b resp_valid=%b expected 1/0", req_ready, resp_valid);
        end
    endtask

    initial begin
        int acc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", {59'd0, resp_valid, req_ready, dp_sign, dp_mix, dp_mult_or_div},
              {59'd0, 5'b01000});
        check("reset_data_a", {resp_data, dp_a}, 64'd0);
        check("reset_tag_b", {27'd0, resp_tag, dp_b}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        issue(3'b000, 32'd7, 32'd6, 5'd1, 32'd42, 2, 3'b000);                       wait_idle();
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0, 2, 3'b100);         wait_idle();
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 2, 3'b000); wait_idle();
        issue(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, 2, 3'b110);         wait_idle();
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 4, 3'b101);         wait_idle();
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, FUSE_LAT, 3'b101);  wait_idle();
        issue(3'b101, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 0, 3'b001);                 wait_idle();
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 0, 3'b101);         wait_idle();
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 0, 3'b101); wait_idle();
        issue(3'b111, 32'd9, 32'd0, 5'd10, 32'd9, 0, 3'b001);                        wait_idle();
        issue(3'b100, 32'd100, 32'd7, 5'd11, 32'd14, 4, 3'b101);                     wait_idle();
        issue(3'b110, 32'd100, 32'd7, 5'd12, 32'd2, FUSE_LAT, 3'b101);               wait_idle();

        // Consumer stalls: result and tag must hold, no new request accepted
        resp_ready = 1'b0;
        issue(3'b000, 32'd3, 32'd5, 5'd14, 32'd15, 2, 3'b000);
        repeat (3) begin
            @(negedge clk);
            check("hold_handshake", {62'd0, resp_valid, req_ready}, {62'd0, 2'b10});
            check("hold_data_tag", {resp_data, 27'd0, resp_tag}, {32'd15, 27'd0, 5'd14});
        end
        resp_ready = 1'b1;
        wait_idle();

        // Flush mid-EXEC: no response, operands kept, ready again afterwards
        accept_only(3'b100, 32'd1000, 32'd10, 5'd20, acc);
        @(negedge clk);
        check("busy_in_exec", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_masks_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("after_flush", {62'd0, req_ready, resp_valid}, {62'd0, 2'b10});
        check("flush_keeps_operands", {dp_a, dp_b}, {32'd1000, 32'd10});
        repeat (6) @(negedge clk);
        check("no_resp_after_flush", 64'(resp_valid), 64'd0);

        // Reset mid-EXEC: everything back to zero, no response
        accept_only(3'b100, 32'd50, 32'd5, 5'd21, acc);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_ctl", {59'd0, resp_valid, req_ready, dp_sign, dp_mix, dp_mult_or_div},
              {59'd0, 5'b01000});
        check("midreset_data_a", {resp_data, dp_a}, 64'd0);
        check("midreset_tag_b", {27'd0, resp_tag, dp_b}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("no_resp_after_reset", 64'(resp_valid), 64'd0);

        issue(3'b000, 32'd2, 32'd3, 5'd15, 32'd6, 2, 3'b000);
        wait_idle();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/m_ext_seq_32.md
Name: m_ext_seq_32

Overview:
- Sequencing controller for the 32-bit M-extension datapath (multiplier_msu plus divider_32, combined unit).
- Accepts one RV32M operation at a time over a valid/ready request channel.
- Registers the operands and holds them stable to the combinational datapath for a programmable multicycle window, then captures and returns the selected 32-bit result.
- Overrides RISC-V divide-by-zero and signed-overflow cases without waiting for the datapath.

Parameters:
- MUL_CYCLES, 2, EXEC cycles for funct3[2]=0 (multicycle path budget, >=1)
- DIV_CYCLES, 4, EXEC cycles for funct3[2]=1 (>=1)
- TAG_W, 5, width of pass-through destination tag

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  abort in-flight op, no response
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_funct3  in  3  RV32M funct3
- req_rs1  in  32  operand a
- req_rs2  in  32  operand b
- req_tag  in  TAG_W  destination tag
- dp_a  out  32  datapath operand a (registered)
- dp_b  out  32  datapath operand b (registered)
- dp_sign  out  1  datapath sign
- dp_mix  out  1  datapath mix (MULHSU)
- dp_mult_or_div  out  1  0 = mult, 1 = div
- dp_uh  in  32  datapath upper half / quotient
- dp_lh  in  32  datapath lower half / remainder
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  32  result
- resp_tag  out  TAG_W  tag of result

Behaviour:
- Reset (rst_n=0 at edge): state IDLE. req_ready=1 after reset. resp_valid=0; resp_data, resp_tag, dp_a, dp_b, dp_sign, dp_mix, dp_mult_or_div, counter all 0. A reset mid-operation discards the operation; no response is produced.
- States: IDLE, EXEC, DONE. req_ready = (state==IDLE) & ~flush.
- Accept occurs at an edge with req_valid & req_ready. At that edge, latch rs1/rs2 into dp_a/dp_b, latch tag, and latch the decoded controls:
  - 000 MUL: sign=0, mix=0, md=0, select lh
  - 001 MULH: sign=1, mix=0, md=0, select uh
  - 010 MULHSU: sign=1, mix=1, md=0, select uh
  - 011 MULHU: sign=0, mix=0, md=0, select uh
  - 100 DIV: sign=1, md=1, select uh
  - 101 DIVU: sign=0, md=1, select uh
  - 110 REM: sign=1, md=1, select lh
  - 111 REMU: sign=0, md=1, select lh
- Special cases are decided at accept, go straight to DONE, and set resp_valid in the next cycle:
  - rs2==0 and div op: quotient = 0xFFFFFFFF; remainder = rs1.
  - Signed DIV/REM with rs1==0x80000000 and rs2==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- Normal path: at the accept edge go to EXEC and load counter = N-1 (N = MUL_CYCLES or DIV_CYCLES).
  - In EXEC, the counter decrements each edge.
  - At the edge where counter==0: resp_data <= selected dp_uh/dp_lh, go to DONE, resp_valid=1.
  - resp_valid is therefore first seen N cycles after the accept edge.
- dp_* outputs are unchanged from accept until the next accept. The datapath inputs must not toggle during EXEC.
- DONE: hold resp_valid, resp_data and resp_tag stable until resp_ready. On resp_valid & resp_ready, go to IDLE and clear resp_valid. No new accept is allowed in the same cycle.
- flush=1 in any state: next state IDLE, resp_valid=0, no response issued. flush takes priority over accept and over resp handshake. Operand registers are kept.
- The counter never underflows. N is fixed at accept time.

Optional Feature:
- Macro: M_SEQ_FUSE_EN.
- When defined, the controller keeps the last captured dp_uh and dp_lh plus a key (rs1, rs2, sign, mix, md) and a fuse_valid bit.
  - An accepted request whose key matches with fuse_valid=1 skips EXEC. resp_data is taken from the stored half and resp_valid is set one cycle after accept.
  - Typical hits: MULH then MUL, DIV then REM. For the MUL/MULHU pair, MUL sign=0 matches MULHU only.
  - fuse_valid is cleared by reset, flush, and special-case results.
- When not defined: no storage, every op uses full latency.

Test Plan:
- MUL rs1=7, rs2=6, MUL_CYCLES=2 -> resp_valid 2 cycles after accept, resp_data=42; dp_a/dp_b stable throughout EXEC.
- MULH rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF; then MULHU with the same operands -> 0x00000000 then 0xFFFFFFFE.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2, DIV_CYCLES=4 -> resp_data=0xFFFFFFFD after 4 cycles; REM with the same operands -> 0xFFFFFFFF.
- DIVU rs1=5, rs2=0 -> 0xFFFFFFFF in 1 cycle; REM rs1=0x80000000, rs2=0xFFFFFFFF -> 0 in 1 cycle.
- Hold resp_ready=0 for 3 cycles in DONE -> resp_data/resp_tag stable, req_ready=0. Then flush during EXEC of the next op -> no resp_valid, req_ready=1 next cycle. Then rst_n=0 mid-EXEC -> all outputs 0.
- With M_SEQ_FUSE_EN: DIV 100/7 (resp 14 after 4 cycles) then REM 100/7 -> resp 2 one cycle after accept. Without the macro, the same REM takes 4 cycles.
